// File: rtl/vc_arbiter_pkg.sv
// Shared types and constants for the VC-to-destination arbiter.
// ARB_ROUND_ROBIN_EN (optional) switches the grant policy to round-robin.
package vc_arbiter_pkg;
  localparam int DATA_W_DEF = 6;
  localparam int DEST_BIT   = 4;
  localparam int NUM_VC     = 2;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  typedef logic [1:0] gnt_t;
  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_VC0  = 2'd1;
  localparam gnt_t GNT_VC1  = 2'd2;
endpackage

// File: rtl/vc_grant_sel.sv
// Combinational eligibility and grant selection over the two VC heads.
// ARB_ROUND_ROBIN_EN adds the last-grant pointer next-state logic.
module vc_grant_sel
  import vc_arbiter_pkg::*;
(
  input  logic              enable,
  input  logic [NUM_VC-1:0] vc_empty,
  input  logic [NUM_VC-1:0] vc_dest,
  input  logic [NUM_VC-1:0] d_afull,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic              last_vc1,
  output logic              last_vc1_nxt,
`endif
  output gnt_t              gnt,
  output logic              gnt_dest
);
  logic [NUM_VC-1:0] elig;

  // The almost-full check is on the head word's own target, same cycle.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_elig
    assign elig[i] = enable & ~vc_empty[i] & ~d_afull[vc_dest[i]];
  end

  always_comb begin
    gnt = GNT_NONE;
`ifdef ARB_ROUND_ROBIN_EN
    if (&elig)        gnt = last_vc1 ? GNT_VC0 : GNT_VC1;
    else if (elig[0]) gnt = GNT_VC0;
    else if (elig[1]) gnt = GNT_VC1;
`else
    if (elig[0])      gnt = GNT_VC0;
    else if (elig[1]) gnt = GNT_VC1;
`endif
    gnt_dest = (gnt == GNT_VC1) ? vc_dest[1] : vc_dest[0];
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_vc1_nxt = last_vc1;
    if (gnt == GNT_VC0)      last_vc1_nxt = 1'b0;
    else if (gnt == GNT_VC1) last_vc1_nxt = 1'b1;
  end
`endif
endmodule

// File: rtl/vc_arbiter.sv
// Pops one eligible VC head per cycle and pushes it to D0/D1 one cycle later.
// ARB_ROUND_ROBIN_EN selects round-robin instead of strict VC0 priority.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              pop_vc0,
  output logic              pop_vc1,
  output logic              push_d0,
  output logic              push_d1,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  cnt_d0,
  output logic [CNT_W-1:0]  cnt_d1,
  output logic              busy
);
  logic [NUM_VC-1:0] vc_empty, vc_dest, d_afull;
  gnt_t              gnt;
  logic              gnt_dest, granted;
  logic [DATA_W-1:0] gnt_word;
  state_t            state, state_nxt;

  assign vc_empty = {vc1_empty, vc0_empty};
  assign vc_dest  = {vc1_data[DEST_BIT], vc0_data[DEST_BIT]};
  assign d_afull  = {d1_almost_full, d0_almost_full};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_vc1, last_vc1_nxt;

  always_ff @(posedge clk or negedge reset)
    if (!reset) last_vc1 <= 1'b1;
    else        last_vc1 <= last_vc1_nxt;
`endif

  // Gating with reset keeps pops low for the whole reset assertion.
  vc_grant_sel u_sel (
    .enable       (enable & reset),
    .vc_empty     (vc_empty),
    .vc_dest      (vc_dest),
    .d_afull      (d_afull),
`ifdef ARB_ROUND_ROBIN_EN
    .last_vc1     (last_vc1),
    .last_vc1_nxt (last_vc1_nxt),
`endif
    .gnt          (gnt),
    .gnt_dest     (gnt_dest)
  );

  assign granted  = (gnt != GNT_NONE);
  assign gnt_word = (gnt == GNT_VC1) ? vc1_data : vc0_data;
  assign pop_vc0  = (gnt == GNT_VC0);
  assign pop_vc1  = (gnt == GNT_VC1);
  assign busy     = (state == XFER);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (granted)  state_nxt = XFER;
      XFER:    if (!granted) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      data_out <= '0;
      cnt_d0   <= '0;
      cnt_d1   <= '0;
    end else begin
      state   <= state_nxt;
      push_d0 <= granted & ~gnt_dest;
      push_d1 <= granted &  gnt_dest;
      if (granted) begin
        data_out <= gnt_word;
        if (gnt_dest) cnt_d1 <= cnt_d1 + 1'b1;
        else          cnt_d0 <= cnt_d0 + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: fixed vector table, directed corner sequences and
// randomized traffic against a queue-based transaction model.
module tb_vc_arbiter;
  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic vc0_empty = 1'b1, vc1_empty = 1'b1;
  logic [DATA_W-1:0] vc0_data = '0, vc1_data = '0;
  logic d0_almost_full = 1'b0, d1_almost_full = 1'b0;
  logic pop_vc0, pop_vc1, push_d0, push_d1, busy;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  cnt_d0, cnt_d1;

  vc_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction model: VC FIFOs as queues, expected registered outputs.
  logic [DATA_W-1:0] q0[$], q1[$];
  logic              m_push0, m_push1, m_busy, m_last1;
  logic [DATA_W-1:0] m_dout;
  logic [CNT_W-1:0]  m_cnt0, m_cnt1;

  logic en_fix, en_rand, af_rand, af0_fix, af1_fix;

  typedef struct {
    logic en; logic e0; logic [5:0] d0; logic e1; logic [5:0] d1;
    logic af0; logic af1;
    logic p0; logic p1; logic pd0; logic pd1; logic [5:0] dout;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_push0 = 1'b0; m_push1 = 1'b0; m_busy = 1'b0; m_last1 = 1'b1;
    m_dout = '0; m_cnt0 = '0; m_cnt1 = '0;
  endtask

  task automatic check_regs();
    chk("push_d0", int'(push_d0), int'(m_push0));
    chk("push_d1", int'(push_d1), int'(m_push1));
    chk("data_out", int'(data_out), int'(m_dout));
    chk("cnt_d0", int'(cnt_d0), int'(m_cnt0));
    chk("cnt_d1", int'(cnt_d1), int'(m_cnt1));
    chk("busy", int'(busy), int'(m_busy));
  endtask

  // One cycle: drive from queues, check everything, advance the model.
  task automatic step();
    logic e0, e1;
    logic [DATA_W-1:0] w;
    int g;
    @(negedge clk);
    enable = en_rand ? ($urandom_range(0, 7) != 0) : en_fix;
    d0_almost_full = af_rand ? ($urandom_range(0, 3) == 0) : af0_fix;
    d1_almost_full = af_rand ? ($urandom_range(0, 3) == 0) : af1_fix;
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data  = vc0_empty ? DATA_W'($urandom) : q0[0];
    vc1_data  = vc1_empty ? DATA_W'($urandom) : q1[0];
    #1;
    check_regs();
    e0 = enable && q0.size() > 0 && !(q0[0][4] ? d1_almost_full : d0_almost_full);
    e1 = enable && q1.size() > 0 && !(q1[0][4] ? d1_almost_full : d0_almost_full);
    g = -1;
`ifdef ARB_ROUND_ROBIN_EN
    if (e0 && e1) g = m_last1 ? 0 : 1;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    if (g >= 0) m_last1 = (g == 1);
`else
    if (e0)      g = 0;
    else if (e1) g = 1;
`endif
    chk("pop_vc0", int'(pop_vc0), int'(g == 0));
    chk("pop_vc1", int'(pop_vc1), int'(g == 1));
    if (g >= 0) begin
      w = (g == 0) ? q0.pop_front() : q1.pop_front();
      m_push0 = !w[4]; m_push1 = w[4]; m_dout = w; m_busy = 1'b1;
      if (w[4]) m_cnt1++; else m_cnt0++;
    end else begin
      m_push0 = 1'b0; m_push1 = 1'b0; m_busy = 1'b0;
    end
  endtask

  // Reset asserted mid-cycle; released just after a rising edge so the
  // following step is the first cycle with reset high.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("pop_vc0_rst", int'(pop_vc0), 0);
    chk("pop_vc1_rst", int'(pop_vc1), 0);
    q0.delete(); q1.delete();
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  initial begin
    en_fix = 1'b1; en_rand = 1'b0; af_rand = 1'b0; af0_fix = 1'b0; af1_fix = 1'b0;
    model_reset();
    tbl = '{
      '{1'b1,1'b0,6'h05,1'b1,6'h00,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,6'h05},
      '{1'b1,1'b0,6'h15,1'b1,6'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,6'h15},
      '{1'b1,1'b1,6'h00,1'b0,6'h12,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,6'h12},
      '{1'b1,1'b1,6'h00,1'b0,6'h02,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,6'h02},
      '{1'b0,1'b0,6'h05,1'b0,6'h12,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,6'h00},
      '{1'b1,1'b0,6'h05,1'b1,6'h00,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,6'h00},
      '{1'b1,1'b1,6'h00,1'b0,6'h17,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,6'h00},
      '{1'b1,1'b1,6'h00,1'b1,6'h00,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,6'h00},
      '{1'b1,1'b0,6'h0A,1'b0,6'h13,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1,6'h13},
      '{1'b1,1'b0,6'h1C,1'b0,6'h03,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,6'h03},
      '{1'b1,1'b0,6'h1C,1'b1,6'h03,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,6'h00},
      '{1'b1,1'b0,6'h2B,1'b1,6'h00,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,6'h2B}
    };

    // Reset state, with a non-empty VC presented
    vc0_empty = 1'b0; vc0_data = 6'h01; enable = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_regs();
    chk("pop_vc0_in_reset", int'(pop_vc0), 0);
    @(posedge clk); #2;
    reset = 1'b1;

    // Vector table: pops checked in-cycle, pushes/data on the next cycle
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i < 12) begin
        enable = tbl[i].en;
        vc0_empty = tbl[i].e0; vc0_data = tbl[i].d0;
        vc1_empty = tbl[i].e1; vc1_data = tbl[i].d1;
        d0_almost_full = tbl[i].af0; d1_almost_full = tbl[i].af1;
      end else begin
        vc0_empty = 1'b1; vc1_empty = 1'b1;
      end
      #1;
      if (i > 0) begin
        chk($sformatf("tbl%0d_push_d0", i - 1), int'(push_d0), int'(tbl[i-1].pd0));
        chk($sformatf("tbl%0d_push_d1", i - 1), int'(push_d1), int'(tbl[i-1].pd1));
        if (tbl[i-1].p0 || tbl[i-1].p1)
          chk($sformatf("tbl%0d_data", i - 1), int'(data_out), int'(tbl[i-1].dout));
      end
      if (i < 12) begin
        chk($sformatf("tbl%0d_pop_vc0", i), int'(pop_vc0), int'(tbl[i].p0));
        chk($sformatf("tbl%0d_pop_vc1", i), int'(pop_vc1), int'(tbl[i].p1));
      end
    end

    // Plain stream on VC0 to D0, first pop right after reset release
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(DATA_W'(i));
    repeat (6) step();
    chk("t1_cnt_d0", int'(cnt_d0), 4);

    // Priority: VC0 first (to D1), then VC1 (to D0)
    do_reset();
    q0.push_back(6'h10); q1.push_back(6'h01);
    repeat (4) step();

    // Continuous traffic on both VCs
    for (int i = 0; i < 8; i++) begin
      q0.push_back(DATA_W'($urandom));
      q1.push_back(DATA_W'($urandom));
    end
    repeat (18) step();

    // D0 almost-full blocks VC0 head, VC1 to D1 proceeds
    af0_fix = 1'b1;
    q0.push_back(6'h03); q0.push_back(6'h05);
    q1.push_back(6'h11); q1.push_back(6'h12);
    repeat (4) step();
    af0_fix = 1'b0;
    repeat (3) step();

    // enable dropped right after a grant
    q0.push_back(6'h07); q0.push_back(6'h08); q0.push_back(6'h09);
    step();
    en_fix = 1'b0;
    repeat (3) step();
    en_fix = 1'b1;
    repeat (4) step();

    // Reset while busy with cnt_d1 = 0xFF
    do_reset();
    for (int i = 0; i < 256; i++) q1.push_back(DATA_W'(i) | 6'h10);
    repeat (255) step();
    @(posedge clk); #2;
    chk("t6_cnt_d1_ff", int'(cnt_d1), 8'hFF);
    chk("t6_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("t6_pop_vc1_rst", int'(pop_vc1), 0);
    do_reset();

    // Counter wrap after 256 D1 transfers
    for (int i = 0; i < 256; i++) q1.push_back(DATA_W'(i) | 6'h10);
    repeat (257) step();
    chk("t6_cnt_d1_wrap", int'(cnt_d1), 0);

    // Randomized traffic
    do_reset();
    en_rand = 1'b1; af_rand = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (q0.size() < 4 && $urandom_range(0, 1) == 1) q0.push_back(DATA_W'($urandom));
      if (q1.size() < 4 && $urandom_range(0, 1) == 1) q1.push_back(DATA_W'($urandom));
      step();
    end
    en_rand = 1'b0; af_rand = 1'b0;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

- Moves 6-bit words from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) of the interconnect device.
- Each cycle it picks one eligible VC head word, pops it, and pushes it one cycle later into the destination selected by data bit 4.
- A VC is eligible only when it is non-empty and its target destination is not signalling almost-full.
- Sits between the VC FIFO stage and the D FIFO stage, and is enabled by the device's top-level init/active state machine.

## Interface

Parameters:
- DATA_W, 6, word width
- CNT_W, 8, width of per-destination transfer counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  high when device state is ACTIVE; low blocks new grants
- vc0_empty, vc1_empty  in  1 each  VC FIFO empty flags
- vc0_data, vc1_data  in  DATA_W each  VC FIFO head word (first-word fall-through)
- d0_almost_full, d1_almost_full  in  1 each  destination FIFO almost-full flags
- pop_vc0, pop_vc1  out  1 each  combinational pop, at most one high per cycle
- push_d0, push_d1  out  1 each  registered push, at most one high per cycle
- data_out  out  DATA_W  registered word, valid with either push
- cnt_d0, cnt_d1  out  CNT_W each  words pushed per destination
- busy  out  1  high while a word is in the output register

## Operation

**Destination decode.** dest(w) = w[4]. 0 → D0, 1 → D1.

**Eligibility.**
- VCi is eligible when all of the following hold: enable = 1, vci_empty = 0, and d{dest(vci_data)}_almost_full = 0.

**Grant selection.**
- Strict priority by default: VC0 is granted over VC1.
- Exactly one pop is asserted for the granted VC, in the same cycle.
- No eligible VC means no pop, no grant.

**Output stage.**
- On a grant at edge N: data_out ← granted word, push_d{dest} ← 1, cnt_d{dest} ← cnt_d{dest} + 1 (mod 2^CNT_W, wraps silently).
- No grant at edge N: both pushes ← 0, data_out holds its value.

**State machine** (2 states):
- IDLE: busy = 0. Moves to XFER on any grant.
- XFER: busy = 1. Stays in XFER while grants continue back-to-back; returns to IDLE on a cycle without a grant.

**enable deassertion.**
- Stops new pops immediately (combinational).
- A word already in the output register is still pushed on the next edge.

**Reset** (asynchronous, any time, including mid-transfer):
- State → IDLE; all pushes, data_out, cnt_d0, cnt_d1, busy → 0.
- Any in-flight word is discarded.
- pop outputs are 0 while reset = 0.

## Timing

- Pop-to-push latency: 1 cycle. Sustained throughput: 1 word/cycle.
- Because of the one-cycle lag, a push may land after almost_full has already been sampled low. Destination almost_full thresholds must therefore leave at least 2 free entries (umbral_D_full ≤ depth − 2). Under that rule, no D FIFO overflow may occur.
- almost_full rising in cycle N blocks grants to that destination in cycle N itself (combinational check). A word popped in cycle N−1 is still pushed.
- Both VCs eligible for the same destination, or for different destinations: still only one grant per cycle.
- Simultaneous reset release and non-empty VC: the first pop is allowed in the first cycle with reset = 1.

## Configuration

- ARB_ROUND_ROBIN_EN defined:
  - A last-grant flop (reset value = VC1) alternates priority.
  - When both VCs are eligible, the VC not granted last is granted.
  - When only one VC is eligible, it is granted and last-grant is updated.
- ARB_ROUND_ROBIN_EN undefined:
  - Strict VC0 priority; no last-grant flop.
  - VC1 can starve while VC0 stays eligible.

## Structure

- Shared package holds:
  - state enum (IDLE, XFER)
  - DEST_BIT = 4
  - DATA_W default
  - grant encoding constants (GNT_NONE, GNT_VC0, GNT_VC1)
- One natural sub-module: vc_grant_sel. Purely combinational; computes the eligibility vector and the grant, and contains the round-robin pointer logic under the macro.

## Test plan

1. Reset, then VC0 holds 0x00..0x03 (dest D0) with VC1 empty, D flags low → pop_vc0 for 4 cycles; push_d0 for 4 cycles 1 cycle later; data_out 0x00..0x03; cnt_d0 = 4.
2. VC0 head 0x10, VC1 head 0x01, both non-empty, strict mode → VC0 granted; push_d1 with 0x10. Then VC1: push_d0 with 0x01.
3. Same stimulus with ARB_ROUND_ROBIN_EN and continuous traffic on both VCs → grants alternate VC0/VC1 each cycle starting with VC0.
4. d0_almost_full = 1 while VC0 head targets D0 and VC1 head targets D1 → VC1 granted; no push_d0 while the flag is high.
5. enable dropped the cycle after a grant → exactly one push follows, then no pops.
6. reset asserted while busy = 1 and cnt_d1 = 0xFF → all outputs 0 immediately. Separately, 256 D1 transfers → cnt_d1 wraps to 0x00.
